pixel_frame_sequencer: RTL and testbench

PIXEL_FRAME_SEQUENCER -- requirements
Module: pixel_frame_sequencer

---
 rtl/pixel_seq_pkg.sv | 34 +++
 rtl/col_shifter.sv | 57 +++++
 rtl/pixel_frame_sequencer.sv | 208 ++++++++++++++++++++
 tb/tb_pixel_frame_sequencer.sv | 458 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pixel_seq_pkg.sv
// ---------------------------------------------------------------------------
// pixel_seq_pkg
//   Shared types and constants for the pixel frame sequencer:
//   - state_e  : sequencer state encoding
//   - strobe_e : which driver strobe (if any) is issued in a cycle
//   - WAIT_*   : strobe/WAIT handshake constants
// ---------------------------------------------------------------------------
package pixel_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_COL   = 3'd2,
    ST_ROW   = 3'd3,
    ST_KEY   = 3'd4,
    ST_WAIT  = 3'd5,
    ST_DONE  = 3'd6
  } state_e;

  // A single strobe selector makes overlapping driver strobes impossible
  // by construction.
  typedef enum logic [1:0] {
    STB_NONE = 2'd0,
    STB_COL  = 2'd1,
    STB_ROW  = 2'd2,
    STB_KEY  = 2'd3
  } strobe_e;

  // Cycles spent in WAIT during which i_drv_rdy is not trusted (the driver
  // has not yet had time to drop its ready after our strobe).
  localparam int unsigned WAIT_IGNORE_CYCLES = 1;
  localparam int unsigned WAIT_CNT_W         = 2;

endpackage

// File: rtl/col_shifter.sv
// ---------------------------------------------------------------------------
// col_shifter
//   Column pattern shift register: parallel load, MSB-first shift, and a flag
//   marking that the bit currently at the MSB is the last one of the pattern.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   load_i     : load data_i (takes priority over shift_i)
//   shift_i    : shift left by one, advance the bit counter
//   data_i     : N_COLS-bit pattern
//   msb_o      : current bit to present to the driver
//   last_o     : msb_o is the final bit of the loaded pattern
// ---------------------------------------------------------------------------
module col_shifter #(
  parameter int N_COLS = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic              shift_i,
  input  logic [N_COLS-1:0] data_i,
  output logic              msb_o,
  output logic              last_o
);

  localparam int CNT_W = (N_COLS > 1) ? $clog2(N_COLS) : 1;

  logic [N_COLS-1:0] sr_q, sr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  always_comb begin
    sr_d  = sr_q;
    cnt_d = cnt_q;
    if (load_i) begin
      sr_d  = data_i;
      cnt_d = '0;
    end else if (shift_i) begin
      sr_d  = sr_q << 1;
      cnt_d = cnt_q + 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of block order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q  <= '0;
      cnt_q <= '0;
    end else begin
      sr_q  <= sr_d;
      cnt_q <= cnt_d;
    end
  end

  assign msb_o  = sr_q[N_COLS-1];
  assign last_o = (cnt_q == CNT_W'(N_COLS - 1));

endmodule

// File: rtl/pixel_frame_sequencer.sv
// ---------------------------------------------------------------------------
// pixel_frame_sequencer
//   Walks a frame row by row: requests a column pattern, shifts it out to the
//   driver one column strobe per bit (MSB first), then a row strobe (data 1
//   only for row 0 so a one-hot row select advances) and a key strobe. Each
//   strobe is followed by a WAIT that ignores ready for a cycle and then waits
//   for the driver to become ready again.
// Ports:
//   clk, rst_n               : clock, asynchronous active-low reset
//   i_start                  : start pulse (honoured only in IDLE)
//   i_abort                  : level, returns to IDLE with no further strobes
//   o_pat_req, o_pat_row     : one-cycle pattern request and its row index
//   i_pat_valid, i_pat_data  : pattern response (MSB shifted first)
//   i_drv_rdy                : driver idle
//   o_write_col/row/key      : one-cycle driver strobes (mutually exclusive)
//   o_data_col, o_data_row   : data bits valid with their strobes
//   o_busy, o_done           : not IDLE / one-cycle frame-complete pulse
// Optional (macro PIXEL_SEQ_LOOP_EN):
//   i_loop                   : at frame end restart at row 0 instead of IDLE
//   o_frame_cnt              : 16-bit wrapping count of completed frames
// ---------------------------------------------------------------------------
module pixel_frame_sequencer
  import pixel_seq_pkg::*;
#(
  parameter int N_COLS = 32,
  parameter int N_ROWS = 32,
  parameter int NB_ROW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_start,
  input  logic              i_abort,
  output logic              o_pat_req,
  output logic [NB_ROW-1:0] o_pat_row,
  input  logic              i_pat_valid,
  input  logic [N_COLS-1:0] i_pat_data,
  input  logic              i_drv_rdy,
`ifdef PIXEL_SEQ_LOOP_EN
  input  logic              i_loop,
  output logic [15:0]       o_frame_cnt,
`endif
  output logic              o_write_col,
  output logic              o_write_row,
  output logic              o_write_key,
  output logic              o_data_col,
  output logic              o_data_row,
  output logic              o_busy,
  output logic              o_done
);

  state_e                  state_q, state_d;
  state_e                  ret_q, ret_d;      // state to resume after WAIT
  logic [WAIT_CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic [NB_ROW-1:0]       row_q, row_d;
  logic                    fetch_first_q, fetch_first_d;

  strobe_e                 strobe;
  logic                    sh_load, sh_shift, sh_msb, sh_last;
  logic                    pat_req, done, data_col, data_row, loop_sel;

`ifdef PIXEL_SEQ_LOOP_EN
  logic [15:0]             frame_cnt_q;
  assign loop_sel = i_loop;
`else
  assign loop_sel = 1'b0;
`endif

  col_shifter #(.N_COLS(N_COLS)) u_col_shifter (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (sh_load),
    .shift_i (sh_shift),
    .data_i  (i_pat_data),
    .msb_o   (sh_msb),
    .last_o  (sh_last)
  );

  // NOTE: every signal written here gets a default first, so no path through
  // the case leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    ret_d      = ret_q;
    wait_cnt_d = wait_cnt_q;
    row_d      = row_q;
    strobe     = STB_NONE;
    sh_load    = 1'b0;
    sh_shift   = 1'b0;
    pat_req    = 1'b0;
    done       = 1'b0;
    data_col   = 1'b0;
    data_row   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          row_d   = '0;
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        // Request is raised only on the entry cycle; the response is taken
        // from the following cycle on.
        pat_req = fetch_first_q;
        if (!fetch_first_q && i_pat_valid) begin
          sh_load = 1'b1;
          state_d = ST_COL;
        end
      end
      ST_COL: begin
        if (i_drv_rdy) begin
          strobe     = STB_COL;
          data_col   = sh_msb;
          sh_shift   = 1'b1;
          ret_d      = sh_last ? ST_ROW : ST_COL;
          wait_cnt_d = '0;
          state_d    = ST_WAIT;
        end
      end
      ST_ROW: begin
        if (i_drv_rdy) begin
          strobe     = STB_ROW;
          data_row   = (row_q == '0);
          ret_d      = ST_KEY;
          wait_cnt_d = '0;
          state_d    = ST_WAIT;
        end
      end
      ST_KEY: begin
        if (i_drv_rdy) begin
          strobe     = STB_KEY;
          ret_d      = (row_q == NB_ROW'(N_ROWS - 1)) ? ST_DONE : ST_FETCH;
          wait_cnt_d = '0;
          state_d    = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (wait_cnt_q < WAIT_CNT_W'(WAIT_IGNORE_CYCLES)) begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end else if (i_drv_rdy) begin
          state_d = ret_q;
          // Returning to FETCH only happens after a non-final key strobe.
          if (ret_q == ST_FETCH) row_d = row_q + 1'b1;
        end
      end
      ST_DONE: begin
        done = 1'b1;
        if (loop_sel) begin
          row_d   = '0;
          state_d = ST_FETCH;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Abort overrides everything, including i_start in IDLE, and suppresses
    // the outputs of the current cycle.
    if (i_abort) begin
      state_d  = ST_IDLE;
      row_d    = row_q;
      strobe   = STB_NONE;
      sh_load  = 1'b0;
      sh_shift = 1'b0;
      pat_req  = 1'b0;
      done     = 1'b0;
      data_col = 1'b0;
      data_row = 1'b0;
    end
  end

  assign fetch_first_d = (state_d == ST_FETCH) && (state_q != ST_FETCH);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      ret_q         <= ST_IDLE;
      wait_cnt_q    <= '0;
      row_q         <= '0;
      fetch_first_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      ret_q         <= ret_d;
      wait_cnt_q    <= wait_cnt_d;
      row_q         <= row_d;
      fetch_first_q <= fetch_first_d;
    end
  end

`ifdef PIXEL_SEQ_LOOP_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    frame_cnt_q <= '0;
    else if (done) frame_cnt_q <= frame_cnt_q + 16'd1;
  end
  assign o_frame_cnt = frame_cnt_q;
`endif

  assign o_pat_req   = pat_req;
  assign o_pat_row   = row_q;
  assign o_write_col = (strobe == STB_COL);
  assign o_write_row = (strobe == STB_ROW);
  assign o_write_key = (strobe == STB_KEY);
  assign o_data_col  = data_col;
  assign o_data_row  = data_row;
  assign o_busy      = (state_q != ST_IDLE);
  assign o_done      = done;

endmodule

// File: tb/tb_pixel_frame_sequencer.sv
// ---------------------------------------------------------------------------
// tb_pixel_frame_sequencer
//   Main instance: N_COLS=4, N_ROWS=3. Second instance: N_COLS=2, N_ROWS=1.
//   Expected strobe streams are derived from the fetched patterns: per row,
//   N_COLS column bits MSB first, one row bit (1 only for row 0), one key.
//   Define PIXEL_SEQ_LOOP_EN to also exercise the looping frame counter.
// ---------------------------------------------------------------------------
module tb_pixel_frame_sequencer;

  localparam int N_COLS = 4;
  localparam int N_ROWS = 3;
  localparam int NB_ROW = 2;

  localparam logic [1:0] K_COL = 2'd1;
  localparam logic [1:0] K_ROW = 2'd2;
  localparam logic [1:0] K_KEY = 2'd3;

  typedef struct packed {
    logic [1:0] kind;
    logic       data;
  } ev_t;

  logic clk = 1'b0;
  logic rst_n;
  logic i_start, i_abort, i_pat_valid, i_drv_rdy, i_loop;
  logic [N_COLS-1:0] i_pat_data;
  logic o_pat_req, o_write_col, o_write_row, o_write_key;
  logic o_data_col, o_data_row, o_busy, o_done;
  logic [NB_ROW-1:0] o_pat_row;
  logic [15:0] o_frame_cnt;

  // single-row instance signals
  logic s_start, s_abort, s_valid, s_rdy, s_loop;
  logic [1:0] s_data;
  logic s_req, s_wcol, s_wrow, s_wkey, s_dcol, s_drow, s_busy, s_done;
  logic [0:0] s_row;
  logic [15:0] s_frame_cnt;

  always #5 clk = ~clk;

  pixel_frame_sequencer #(.N_COLS(N_COLS), .N_ROWS(N_ROWS), .NB_ROW(NB_ROW)) dut (
    .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_abort(i_abort),
    .o_pat_req(o_pat_req), .o_pat_row(o_pat_row),
    .i_pat_valid(i_pat_valid), .i_pat_data(i_pat_data), .i_drv_rdy(i_drv_rdy),
`ifdef PIXEL_SEQ_LOOP_EN
    .i_loop(i_loop), .o_frame_cnt(o_frame_cnt),
`endif
    .o_write_col(o_write_col), .o_write_row(o_write_row), .o_write_key(o_write_key),
    .o_data_col(o_data_col), .o_data_row(o_data_row), .o_busy(o_busy), .o_done(o_done)
  );

  pixel_frame_sequencer #(.N_COLS(2), .N_ROWS(1), .NB_ROW(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .i_start(s_start), .i_abort(s_abort),
    .o_pat_req(s_req), .o_pat_row(s_row),
    .i_pat_valid(s_valid), .i_pat_data(s_data), .i_drv_rdy(s_rdy),
`ifdef PIXEL_SEQ_LOOP_EN
    .i_loop(s_loop), .o_frame_cnt(s_frame_cnt),
`endif
    .o_write_col(s_wcol), .o_write_row(s_wrow), .o_write_key(s_wkey),
    .o_data_col(s_dcol), .o_data_row(s_drow), .o_busy(s_busy), .o_done(s_done)
  );

  logic [NB_ROW+7:0] outs;
  assign outs = {o_pat_req, o_pat_row, o_write_col, o_write_row, o_write_key,
                 o_data_col, o_data_row, o_busy, o_done};

  int errors = 0;
  int checks = 0;

  ev_t               got_q[$];
  ev_t               exp_q[$];
  logic [N_COLS-1:0] fetched_q[$];
  logic [N_COLS-1:0] pat_fixed_q[$];
  int                done_cnt, req_cnt;

  // Reference stream: fetch k serves row k % N_ROWS.
  function automatic void build_exp(input int limit);
    ev_t e;
    exp_q.delete();
    foreach (fetched_q[k]) begin
      for (int b = N_COLS - 1; b >= 0; b--) begin
        e.kind = K_COL; e.data = fetched_q[k][b];
        exp_q.push_back(e);
      end
      e.kind = K_ROW; e.data = ((k % N_ROWS) == 0);
      exp_q.push_back(e);
      e.kind = K_KEY; e.data = 1'b0;
      exp_q.push_back(e);
    end
    if (limit >= 0)
      while (exp_q.size() > limit) void'(exp_q.pop_back());
  endfunction

  // Starts a frame and plays pattern source + driver, sampling on negedges.
  task automatic run_seq(input int stop_done, input int drop, input int vdelay,
                         input int abort_after, input bit reset_on_key,
                         input bit noise, input bit loop3);
    int  vcnt = 0, dcnt = 0, n, cyc = 0;
    bit  waiting = 0, prev_req = 0, finished = 0;
    ev_t ev;
    logic [N_COLS-1:0] d;
    got_q.delete(); fetched_q.delete();
    done_cnt = 0; req_cnt = 0;
    i_loop = loop3;
    @(posedge clk); #1; i_start = 1'b1; i_drv_rdy = 1'b1;
    @(posedge clk); #1; i_start = 1'b0;
    while (!finished && cyc < 2000) begin
      @(negedge clk); cyc++;
      n = int'(o_write_col) + int'(o_write_row) + int'(o_write_key);
      if (n != 0) begin
        checks++;
        if (n > 1) begin
          errors++; $display("FAIL strobe_overlap: %0d strobes in one cycle, required 1", n);
        end
        checks++;
        if (i_drv_rdy !== 1'b1) begin
          errors++; $display("FAIL strobe_rdy: strobe with rdy=%b, required rdy=1", i_drv_rdy);
        end
        checks++;
        if (waiting) begin
          errors++; $display("FAIL strobe_in_fetch: strobe=1 while pattern pending, required 0");
        end
        ev.kind = o_write_col ? K_COL : (o_write_row ? K_ROW : K_KEY);
        ev.data = o_write_col ? o_data_col : (o_write_row ? o_data_row : 1'b0);
        got_q.push_back(ev);
        if (drop > 0) dcnt = drop;
      end
      if (o_pat_req === 1'b1) begin
        checks++;
        if (prev_req) begin
          errors++; $display("FAIL pat_req_width: req=1 on consecutive cycles, required one-cycle pulse");
        end
        checks++;
        if (o_pat_row !== NB_ROW'(req_cnt % N_ROWS)) begin
          errors++; $display("FAIL pat_row: got %0d, required %0d", o_pat_row, req_cnt % N_ROWS);
        end
        req_cnt++; waiting = 1; vcnt = vdelay;
      end
      prev_req = o_pat_req;
      if (o_done === 1'b1) done_cnt++;

      if (abort_after != 0 && n != 0 && got_q.size() == abort_after) begin
        finished = 1;
      end else if (reset_on_key && n != 0 && ev.kind == K_KEY) begin
        rst_n = 1'b0; finished = 1;
      end else if (stop_done != 0 && done_cnt == stop_done) begin
        @(posedge clk); #1;
        i_start = 1'b0; i_pat_valid = 1'b0; i_drv_rdy = 1'b1; i_loop = 1'b0;
        finished = 1;
      end else begin
        @(posedge clk); #1;
        i_pat_valid = 1'b0;
        if (waiting) begin
          if (vcnt == 0) begin
            if (pat_fixed_q.size() != 0) d = pat_fixed_q.pop_front();
            else d = N_COLS'($urandom);
            i_pat_valid = 1'b1; i_pat_data = d;
            fetched_q.push_back(d); waiting = 0;
          end else begin
            vcnt--;
          end
        end else if (noise && $urandom_range(0, 3) == 0) begin
          i_pat_valid = 1'b1; i_pat_data = N_COLS'($urandom);
        end
        i_drv_rdy = (dcnt == 0);
        if (dcnt > 0) dcnt--;
        i_start = noise && ($urandom_range(0, 5) == 0);
        i_loop  = loop3 && (done_cnt < 2);
      end
    end
    checks++;
    if (!finished) begin
      errors++; $display("FAIL run_timeout: sequence did not reach its end within %0d cycles", cyc);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++;
    if (outs !== '0) begin
      errors++; $display("FAIL reset_outputs: got %b, required all 0", outs);
    end
`ifdef PIXEL_SEQ_LOOP_EN
    checks++;
    if (o_frame_cnt !== 16'd0) begin
      errors++; $display("FAIL reset_frame_cnt: got %0d, required 0", o_frame_cnt);
    end
`endif
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (o_busy !== 1'b0) begin
      errors++; $display("FAIL reset_idle: busy=%b, required 0", o_busy);
    end
  endtask

  task automatic test_basic();
    int keys = 0;
    pat_fixed_q = '{4'hA, 4'h5, 4'hF};
    run_seq(1, 0, 0, 0, 0, 0, 0);
    build_exp(-1);
    checks++;
    if (got_q.size() != 18) begin
      errors++; $display("FAIL basic_total: got %0d strobes, required 18", got_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL basic_seq[%0d]: got kind %0d data %b, required kind %0d data %b",
                           i, got_q[i].kind, got_q[i].data, exp_q[i].kind, exp_q[i].data);
      end
    end
    foreach (got_q[i]) if (got_q[i].kind == K_KEY) keys++;
    checks++;
    if (keys != 3) begin
      errors++; $display("FAIL basic_keys: got %0d, required 3", keys);
    end
    checks++;
    if (done_cnt != 1) begin
      errors++; $display("FAIL basic_done: got %0d pulses, required 1", done_cnt);
    end
    @(negedge clk);
    checks++;
    if (o_busy !== 1'b0) begin
      errors++; $display("FAIL basic_idle: busy=%b, required 0", o_busy);
    end
  endtask

  task automatic test_rdy_drop();
    run_seq(1, 5, 0, 0, 0, 1, 0);
    build_exp(-1);
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++; $display("FAIL drop_total: got %0d strobes, required %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL drop_seq[%0d]: got kind %0d data %b, required kind %0d data %b",
                           i, got_q[i].kind, got_q[i].data, exp_q[i].kind, exp_q[i].data);
      end
    end
    checks++;
    if (done_cnt != 1) begin
      errors++; $display("FAIL drop_done: got %0d pulses, required 1", done_cnt);
    end
  endtask

  task automatic test_valid_delay();
    run_seq(1, 0, 10, 0, 0, 0, 0);
    build_exp(-1);
    checks++;
    if (req_cnt != N_ROWS) begin
      errors++; $display("FAIL delay_reqs: got %0d requests, required %0d", req_cnt, N_ROWS);
    end
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++; $display("FAIL delay_total: got %0d strobes, required %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL delay_seq[%0d]: got kind %0d data %b, required kind %0d data %b",
                           i, got_q[i].kind, got_q[i].data, exp_q[i].kind, exp_q[i].data);
      end
    end
  endtask

  task automatic test_abort();
    int extra = 0, dones = 0, reqs = 0;
    run_seq(0, 0, 0, N_COLS + 2 + 2, 0, 0, 0);
    build_exp(N_COLS + 2 + 2);
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++; $display("FAIL abort_total: got %0d strobes, required %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL abort_seq[%0d]: got kind %0d data %b, required kind %0d data %b",
                           i, got_q[i].kind, got_q[i].data, exp_q[i].kind, exp_q[i].data);
      end
    end
    @(posedge clk); #1; i_abort = 1'b1; i_drv_rdy = 1'b1;
    @(posedge clk); #1; i_abort = 1'b0;
    @(negedge clk);
    checks++;
    if (o_busy !== 1'b0) begin
      errors++; $display("FAIL abort_idle: busy=%b, required 0", o_busy);
    end
    repeat (30) begin
      @(negedge clk);
      if (o_write_col || o_write_row || o_write_key) extra++;
      if (o_done) dones++;
      if (o_pat_req) reqs++;
      @(posedge clk); #1;
      i_pat_valid = ($urandom_range(0, 1) == 1); i_pat_data = N_COLS'($urandom);
    end
    i_pat_valid = 1'b0;
    checks++;
    if (extra != 0) begin
      errors++; $display("FAIL abort_strobes: got %0d after abort, required 0", extra);
    end
    checks++;
    if (dones != 0 || done_cnt != 0) begin
      errors++; $display("FAIL abort_done: got %0d pulses, required 0", dones + done_cnt);
    end
    checks++;
    if (reqs != 0) begin
      errors++; $display("FAIL abort_req: got %0d requests after abort, required 0", reqs);
    end
  endtask

  task automatic test_start_abort_idle();
    @(posedge clk); #1; i_start = 1'b1; i_abort = 1'b1;
    @(posedge clk); #1; i_start = 1'b0; i_abort = 1'b0;
    @(negedge clk);
    checks++;
    if (o_busy !== 1'b0 || o_pat_req !== 1'b0) begin
      errors++; $display("FAIL start_abort: busy=%b req=%b, required 0 0", o_busy, o_pat_req);
    end
  endtask

  task automatic test_reset_mid_frame();
    run_seq(0, 0, 0, 0, 1, 0, 0);
    #1;
    checks++;
    if (outs !== '0) begin
      errors++; $display("FAIL midreset_outputs: got %b, required all 0", outs);
    end
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (outs !== '0) begin
        errors++; $display("FAIL midreset_hold: got %b, required all 0", outs);
      end
    end
    rst_n = 1'b1;
    run_seq(1, 0, 0, 0, 0, 0, 0);
    build_exp(-1);
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++; $display("FAIL midreset_total: got %0d strobes, required %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL midreset_seq[%0d]: got kind %0d data %b, required kind %0d data %b",
                           i, got_q[i].kind, got_q[i].data, exp_q[i].kind, exp_q[i].data);
      end
    end
    checks++;
    if (got_q.size() > N_COLS && got_q[N_COLS] !== ev_t'({K_ROW, 1'b1})) begin
      errors++; $display("FAIL midreset_row0: first row strobe kind %0d data %b, required kind 2 data 1",
                         got_q[N_COLS].kind, got_q[N_COLS].data);
    end
  endtask

  task automatic test_single_row();
    ev_t s_got[$];
    ev_t e;
    logic [1:0] d;
    int reqs = 0, dones = 0, cyc = 0;
    bit pend = 0;
    d = 2'($urandom);
    s_rdy = 1'b1;
    @(posedge clk); #1; s_start = 1'b1;
    @(posedge clk); #1; s_start = 1'b0;
    while (dones == 0 && cyc < 200) begin
      @(negedge clk); cyc++;
      if (s_req) begin reqs++; pend = 1; end
      if (s_wcol || s_wrow || s_wkey) begin
        e.kind = s_wcol ? K_COL : (s_wrow ? K_ROW : K_KEY);
        e.data = s_wcol ? s_dcol : (s_wrow ? s_drow : 1'b0);
        s_got.push_back(e);
      end
      if (s_done) dones++;
      @(posedge clk); #1;
      s_valid = pend; s_data = d; pend = 0;
    end
    s_valid = 1'b0;
    checks++;
    if (dones != 1 || reqs != 1) begin
      errors++; $display("FAIL single_counts: done=%0d req=%0d, required 1 1", dones, reqs);
    end
    checks++;
    if (s_got.size() != 4) begin
      errors++; $display("FAIL single_total: got %0d strobes, required 4", s_got.size());
    end else begin
      checks++;
      if (s_got[0] !== ev_t'({K_COL, d[1]}) || s_got[1] !== ev_t'({K_COL, d[0]}) ||
          s_got[2] !== ev_t'({K_ROW, 1'b1}) || s_got[3] !== ev_t'({K_KEY, 1'b0})) begin
        errors++; $display("FAIL single_seq: got %b %b %b %b for pattern %b", s_got[0], s_got[1],
                           s_got[2], s_got[3], d);
      end
    end
    @(negedge clk);
    checks++;
    if (s_busy !== 1'b0) begin
      errors++; $display("FAIL single_idle: busy=%b, required 0", s_busy);
    end
  endtask

`ifdef PIXEL_SEQ_LOOP_EN
  task automatic test_loop();
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    run_seq(3, 0, 0, 0, 0, 0, 1);
    build_exp(-1);
    checks++;
    if (done_cnt != 3) begin
      errors++; $display("FAIL loop_done: got %0d pulses, required 3", done_cnt);
    end
    checks++;
    if (o_frame_cnt !== 16'd3) begin
      errors++; $display("FAIL loop_frame_cnt: got %0d, required 3", o_frame_cnt);
    end
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++; $display("FAIL loop_total: got %0d strobes, required %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL loop_seq[%0d]: got kind %0d data %b, required kind %0d data %b",
                           i, got_q[i].kind, got_q[i].data, exp_q[i].kind, exp_q[i].data);
      end
    end
    @(negedge clk);
    checks++;
    if (o_busy !== 1'b0) begin
      errors++; $display("FAIL loop_idle: busy=%b, required 0", o_busy);
    end
  endtask
`endif

  initial begin
    rst_n = 1'b0; i_start = 1'b0; i_abort = 1'b0; i_pat_valid = 1'b0;
    i_pat_data = '0; i_drv_rdy = 1'b1; i_loop = 1'b0;
    s_start = 1'b0; s_abort = 1'b0; s_valid = 1'b0; s_data = '0;
    s_rdy = 1'b1; s_loop = 1'b0;
    test_reset();
    test_basic();
    test_rdy_drop();
    test_valid_delay();
    test_abort();
    test_start_abort_idle();
    test_reset_mid_frame();
    test_single_row();
`ifdef PIXEL_SEQ_LOOP_EN
    test_loop();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
